apb_gpio_filter: RTL and testbench



---
 rtl/apb_gpio_filter.sv | 150 +++++++++++++++
 tb/tb_apb_gpio_filter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_gpio_filter.sv
// APB3 input-GPIO block: 2-flop synchronisers, per-channel debounce filter and
// run-time programmable level/edge interrupts with write-one-to-clear status.
module apb_gpio_filter #(
  parameter int unsigned IO_NUM    = 8,
  parameter int unsigned APB_WIDTH = 32,
  parameter int unsigned DEB_W     = 8
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [7:0]           PADDR,
  input  logic [APB_WIDTH-1:0] PWDATA,
  output logic [APB_WIDTH-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  input  logic [IO_NUM-1:0]    GPIO_IN,
  output logic [IO_NUM-1:0]    INT,
  output logic                 INT_OR
);

  localparam logic [5:0] A_FILT   = 6'd0;
  localparam logic [5:0] A_INT_EN = 6'd1;
  localparam logic [5:0] A_EDGE   = 6'd2;
  localparam logic [5:0] A_POL    = 6'd3;
  localparam logic [5:0] A_BOTH   = 6'd4;
  localparam logic [5:0] A_STAT   = 6'd5;
  localparam logic [5:0] A_DEB    = 6'd6;
  localparam logic [5:0] A_RAW    = 6'd7;

  logic [5:0]        widx;
  logic              mapped;
  logic              read_only;
  logic              access;
  logic              wr;
  logic [IO_NUM-1:0] sync1;
  logic [IO_NUM-1:0] s;
  logic [IO_NUM-1:0] filt;
  logic [IO_NUM-1:0] int_en;
  logic [IO_NUM-1:0] edge_mode;
  logic [IO_NUM-1:0] pol;
  logic [IO_NUM-1:0] both;
  logic [IO_NUM-1:0] stat;
  logic [IO_NUM-1:0] upd;
  logic [IO_NUM-1:0] ev;
  logic [IO_NUM-1:0] w1c;
  logic [DEB_W-1:0]  deb_limit;
  logic [DEB_W-1:0]  cnt [IO_NUM];
  logic              unused_bits;

  // Address decode; byte-lane bits and upper write-data bits carry no meaning
  assign widx        = PADDR[7:2];
  assign unused_bits = ^{PADDR[1:0], PWDATA};
  assign mapped      = (widx[5:3] == 3'd0);
  assign read_only   = (widx == A_FILT) || (widx == A_RAW);
  assign access      = PSEL & PENABLE;
  assign PSLVERR     = access & (~mapped | (PWRITE & read_only));
  assign wr          = access & PWRITE & ~PSLVERR;
  assign PREADY      = 1'b1;
  assign w1c         = (wr && (widx == A_STAT)) ? PWDATA[IO_NUM-1:0] : '0;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      int_en    <= '0;
      edge_mode <= '0;
      pol       <= '0;
      both      <= '0;
      deb_limit <= '0;
    end else if (wr) begin
      case (widx)
        A_INT_EN: int_en    <= PWDATA[IO_NUM-1:0];
        A_EDGE:   edge_mode <= PWDATA[IO_NUM-1:0];
        A_POL:    pol       <= PWDATA[IO_NUM-1:0];
        A_BOTH:   both      <= PWDATA[IO_NUM-1:0];
        A_DEB:    deb_limit <= PWDATA[DEB_W-1:0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL) begin
      case (widx)
        A_FILT:   PRDATA = APB_WIDTH'(filt);
        A_INT_EN: PRDATA = APB_WIDTH'(int_en);
        A_EDGE:   PRDATA = APB_WIDTH'(edge_mode);
        A_POL:    PRDATA = APB_WIDTH'(pol);
        A_BOTH:   PRDATA = APB_WIDTH'(both);
        A_STAT:   PRDATA = APB_WIDTH'(stat);
        A_DEB:    PRDATA = APB_WIDTH'(deb_limit);
        A_RAW:    PRDATA = APB_WIDTH'(s);
        default:  PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= GPIO_IN;
      s     <= sync1;
    end
  end

  // A channel's filtered value flips once s has disagreed for DEB_LIMIT+1 edges
  always_comb begin
    upd = '0;
    for (int unsigned i = 0; i < IO_NUM; i++) begin
      upd[i] = (s[i] != filt[i]) && (cnt[i] >= deb_limit);
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      filt <= '0;
      for (int unsigned i = 0; i < IO_NUM; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      filt <= filt ^ upd;
      for (int unsigned i = 0; i < IO_NUM; i++) begin
        if ((s[i] == filt[i]) || upd[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Edge direction is taken from the new filtered value, which equals s
  assign ev = int_en & ((edge_mode & upd & (both | ~(s ^ pol))) |
                        (~edge_mode & ~(filt ^ pol)));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      stat <= '0;
    end else begin
      stat <= (stat & ~w1c) | ev;
    end
  end

  assign INT    = stat & int_en;
  assign INT_OR = |INT;

endmodule

// File: tb/tb_apb_gpio_filter.sv
// Directed self-checking bench for apb_gpio_filter (IO_NUM=8, APB_WIDTH=32, DEB_W=8).
module tb_apb_gpio_filter;

  localparam int unsigned IO_NUM    = 8;
  localparam int unsigned APB_WIDTH = 32;
  localparam int unsigned DEB_W     = 8;

  localparam logic [7:0] R_FILT = 8'h00, R_INT_EN = 8'h04, R_EDGE = 8'h08, R_POL = 8'h0C;
  localparam logic [7:0] R_BOTH = 8'h10, R_STAT = 8'h14, R_DEB = 8'h18, R_RAW = 8'h1C;

  logic                 clk;
  logic                 rst;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [7:0]           paddr;
  logic [APB_WIDTH-1:0] pwdata;
  logic [APB_WIDTH-1:0] prdata;
  logic                 pready;
  logic                 pslverr;
  logic [IO_NUM-1:0]    gpio_in;
  logic [IO_NUM-1:0]    int_line;
  logic                 int_or;

  int tests = 0;
  int fails = 0;
  logic [31:0] rd;
  logic        err;

  apb_gpio_filter #(.IO_NUM(IO_NUM), .APB_WIDTH(APB_WIDTH), .DEB_W(DEB_W)) dut (
    .PCLK(clk), .PRESET(rst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .GPIO_IN(gpio_in), .INT(int_line), .INT_OR(int_or)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; the write commits on the second edge
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic e);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    tick(1);
    penable = 1'b1;
    #1 e = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    tick(1);
    penable = 1'b1;
    #1 d = prdata; e = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = R_RAW;
    pwdata = '0; gpio_in = 8'hFF;
    tick(3);
    tests++; if (int_line !== 8'h00 || int_or !== 1'b0) begin fails++;
      $display("FAIL reset_int: got %h/%b expected 00/0", int_line, int_or); end
    tests++; if (prdata !== 32'h0 || pslverr !== 1'b0 || pready !== 1'b1) begin fails++;
      $display("FAIL reset_apb: got %h/%b/%b expected 0/0/1", prdata, pslverr, pready); end
    rst = 1'b0;
    tick(1);
    tests++; if (prdata !== 32'h0) begin fails++;
      $display("FAIL raw_edge1: got %h expected 0", prdata); end
    tick(1);
    tests++; if (prdata !== 32'hFF) begin fails++;
      $display("FAIL raw_edge2: got %h expected ff", prdata); end
    paddr = R_FILT; #1;
    tests++; if (prdata !== 32'h0) begin fails++;
      $display("FAIL filt_edge2: got %h expected 0", prdata); end
    tick(1);
    tests++; if (prdata !== 32'hFF) begin fails++;
      $display("FAIL filt_edge3: got %h expected ff", prdata); end
    psel = 1'b0;
    apb_read(R_STAT, rd, err);
    tests++; if (rd !== 32'h0 || int_or !== 1'b0) begin fails++;
      $display("FAIL reset_stat: got %h/%b expected 0/0", rd, int_or); end
  endtask

  task automatic test_debounce();
    gpio_in = 8'h00;
    tick(6);
    apb_write(R_DEB, 32'd4, err);
    apb_write(R_INT_EN, 32'h1, err);
    apb_write(R_EDGE, 32'h1, err);
    apb_write(R_POL, 32'h1, err);
    apb_write(R_STAT, 32'hFF, err);
    apb_read(R_FILT, rd, err);
    tests++; if (rd !== 32'h0) begin fails++;
      $display("FAIL deb_init_filt: got %h expected 0", rd); end
    // 3-cycle glitch stays below the limit
    gpio_in[0] = 1'b1; tick(3); gpio_in[0] = 1'b0; tick(10);
    apb_read(R_FILT, rd, err);
    tests++; if (rd !== 32'h0 || int_line !== 8'h00) begin fails++;
      $display("FAIL glitch_filt: got %h/%h expected 0/00", rd, int_line); end
    apb_read(R_STAT, rd, err);
    tests++; if (rd !== 32'h0) begin fails++;
      $display("FAIL glitch_stat: got %h expected 0", rd); end
    gpio_in[0] = 1'b1;
    tick(6);
    tests++; if (int_line[0] !== 1'b0) begin fails++;
      $display("FAIL rise_edge6: got %b expected 0", int_line[0]); end
    tick(1);
    tests++; if (int_line[0] !== 1'b1 || int_or !== 1'b1) begin fails++;
      $display("FAIL rise_edge7: got %b/%b expected 1/1", int_line[0], int_or); end
    apb_read(R_FILT, rd, err);
    tests++; if (rd !== 32'h1) begin fails++;
      $display("FAIL rise_filt: got %h expected 1", rd); end
    apb_read(R_STAT, rd, err);
    tests++; if (rd !== 32'h1) begin fails++;
      $display("FAIL rise_stat: got %h expected 1", rd); end
    apb_write(R_STAT, 32'h1, err);
    apb_read(R_STAT, rd, err);
    tests++; if (rd !== 32'h0 || int_or !== 1'b0) begin fails++;
      $display("FAIL w1c_edge: got %h/%b expected 0/0", rd, int_or); end
    gpio_in[0] = 1'b0; tick(10);
    apb_read(R_STAT, rd, err);
    tests++; if (rd !== 32'h0) begin fails++;
      $display("FAIL fall_ignored: got %h expected 0", rd); end
  endtask

  task automatic test_both_edges();
    apb_write(R_EDGE, 32'h3, err);
    apb_write(R_BOTH, 32'h2, err);
    apb_write(R_INT_EN, 32'h3, err);
    gpio_in[1] = 1'b1; tick(10);
    apb_read(R_STAT, rd, err);
    tests++; if (rd !== 32'h2) begin fails++;
      $display("FAIL both_rise: got %h expected 2", rd); end
    apb_write(R_STAT, 32'h2, err);
    apb_read(R_STAT, rd, err);
    tests++; if (rd !== 32'h0) begin fails++;
      $display("FAIL both_w1c: got %h expected 0", rd); end
    gpio_in[1] = 1'b0; tick(10);
    apb_read(R_STAT, rd, err);
    tests++; if (rd !== 32'h2) begin fails++;
      $display("FAIL both_fall: got %h expected 2", rd); end
    apb_write(R_STAT, 32'h2, err);
    // W1C committed on edge 7, the same edge the filter updates
    gpio_in[1] = 1'b1; tick(5);
    tests++; if (int_line !== 8'h00) begin fails++;
      $display("FAIL both_pre: got %h expected 00", int_line); end
    apb_write(R_STAT, 32'h2, err);
    tests++; if (int_line !== 8'h02) begin fails++;
      $display("FAIL both_simul_int: got %h expected 02", int_line); end
    apb_read(R_STAT, rd, err);
    tests++; if (rd !== 32'h2) begin fails++;
      $display("FAIL both_simul_stat: got %h expected 2", rd); end
  endtask

  task automatic test_level_low();
    apb_write(R_INT_EN, 32'h7, err);
    apb_write(R_STAT, 32'h4, err);
    apb_read(R_STAT, rd, err);
    tests++; if (rd !== 32'h6 || int_line !== 8'h06) begin fails++;
      $display("FAIL level_held: got %h/%h expected 6/06", rd, int_line); end
    gpio_in[2] = 1'b1; tick(10);
    apb_write(R_STAT, 32'h4, err);
    apb_read(R_STAT, rd, err);
    tests++; if (rd !== 32'h2) begin fails++;
      $display("FAIL level_cleared: got %h expected 2", rd); end
  endtask

  task automatic test_apb_errors();
    apb_write(R_FILT, 32'hFF, err);
    tests++; if (err !== 1'b1) begin fails++;
      $display("FAIL wr_filt_err: got %b expected 1", err); end
    apb_read(R_FILT, rd, err);
    tests++; if (rd !== 32'h6 || err !== 1'b0) begin fails++;
      $display("FAIL filt_unchanged: got %h/%b expected 6/0", rd, err); end
    apb_write(R_RAW, 32'hFF, err);
    tests++; if (err !== 1'b1) begin fails++;
      $display("FAIL wr_raw_err: got %b expected 1", err); end
    apb_read(8'h20, rd, err);
    tests++; if (rd !== 32'h0 || err !== 1'b1) begin fails++;
      $display("FAIL rd_unmapped: got %h/%b expected 0/1", rd, err); end
    tests++; if (prdata !== 32'h0) begin fails++;
      $display("FAIL idle_prdata: got %h expected 0", prdata); end
    apb_write(R_INT_EN, 32'hFFFFFFFF, err);
    apb_read(R_INT_EN, rd, err);
    tests++; if (rd !== 32'hFF || err !== 1'b0) begin fails++;
      $display("FAIL int_en_width: got %h/%b expected ff/0", rd, err); end
    apb_write(R_DEB, 32'hFFFFFFFF, err);
    apb_read(R_DEB, rd, err);
    tests++; if (rd !== 32'hFF) begin fails++;
      $display("FAIL deb_width: got %h expected ff", rd); end
    apb_write(R_DEB, 32'd4, err);
    apb_write(R_INT_EN, 32'h1, err);
  endtask

  task automatic test_reset_mid();
    apb_write(R_EDGE, 32'h1, err);
    apb_write(R_BOTH, 32'h0, err);
    apb_write(R_POL, 32'h1, err);
    apb_write(R_STAT, 32'hFF, err);
    apb_read(R_STAT, rd, err);
    tests++; if (rd !== 32'h0) begin fails++;
      $display("FAIL mid_pre_clear: got %h expected 0", rd); end
    gpio_in[0] = 1'b1; tick(10);
    apb_read(R_STAT, rd, err);
    tests++; if (rd !== 32'h1) begin fails++;
      $display("FAIL mid_pre_stat: got %h expected 1", rd); end
    gpio_in[0] = 1'b0; tick(4);
    psel = 1'b1; pwrite = 1'b1; paddr = R_DEB; pwdata = 32'h33; penable = 1'b0;
    tick(1);
    penable = 1'b1; rst = 1'b1; gpio_in = 8'h00;
    #1;
    tests++; if (int_line !== 8'h00 || int_or !== 1'b0) begin fails++;
      $display("FAIL mid_rst_int: got %h/%b expected 00/0", int_line, int_or); end
    #2 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    tick(2);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      apb_read(8'(k * 4), rd, err);
      tests++; if (rd !== 32'h0 || err !== 1'b0) begin fails++;
        $display("FAIL mid_reg_%0h: got %h/%b expected 0/0", k * 4, rd, err); end
    end
    tests++; if (int_line !== 8'h00 || int_or !== 1'b0) begin fails++;
      $display("FAIL mid_post_int: got %h/%b expected 00/0", int_line, int_or); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_both_edges();
    test_level_low();
    test_apb_errors();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
